axi4_m_rd_mo: RTL and testbench

//  Multi-outstanding AXI4 master read engine for the QEMU/HDL cosim PCIe bridge.

---
 rtl/axi4_m_rd_mo_if.sv | 36 +++
 rtl/axi4_m_rd_mo.sv | 190 +++++++++++++++++++
 tb/tb_axi4_m_rd_mo.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_m_rd_mo_if.sv
// AXI4 read-address and read-data channels used by the multi-outstanding read master.
//   master modport : drives AR payload/valid and rready, receives arready and R beats
//   slave modport  : the memory-side view of the same signals
interface axi4_m_rd_mo_if #(
  parameter int TAGW = 3,
  parameter int ADRW = 64,
  parameter int DATW = 256
);
  logic [TAGW-1:0] arid;
  logic [ADRW-1:0] araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [TAGW-1:0] rid;
  logic [DATW-1:0] rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_m_rd_mo.sv
// Multi-outstanding AXI4 read master for the cosim PCIe bridge.
// Host read requests are queued, issued as AR bursts with distinct IDs (up to
// MAXOUT in flight), and returned R beats are tagged with the sequence number
// of the request that caused them.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   req_addr/len/valid/ready     request input (len = beats - 1)
//   m_axi (master modport)       AXI4 AR and R channels
//   o_cpl_seq/data/resp/last     completion beat, o_cpl_valid / i_cpl_ready handshake
//   o_inflight                   bursts issued whose rlast has not been accepted
//   o_err                        sticky error (bad rresp, unknown rid, 4KB crossing)
module axi4_m_rd_mo #(
  parameter int         TAGW   = 3,
  parameter int         ADRW   = 64,
  parameter int         DATW   = 256,
  parameter logic [2:0] SIZE   = 3'b101,
  parameter int         QDEPTH = 4,
  parameter int         MAXOUT = 4,
  parameter int         SEQW   = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [ADRW-1:0]              req_addr,
  input  logic [7:0]                   req_len,
  input  logic                         req_valid,
  output logic                         req_ready,
  axi4_m_rd_mo_if.master               m_axi,
  output logic [SEQW-1:0]              o_cpl_seq,
  output logic [DATW-1:0]              o_cpl_data,
  output logic [1:0]                   o_cpl_resp,
  output logic                         o_cpl_last,
  output logic                         o_cpl_valid,
  input  logic                         i_cpl_ready,
  output logic [$clog2(MAXOUT+1)-1:0]  o_inflight,
  output logic                         o_err
);
  localparam int NID   = 2**TAGW;
  localparam int QAW   = $clog2(QDEPTH);
  localparam int INW   = $clog2(MAXOUT+1);
  localparam int STBW  = DATW/8;
  localparam int SHIFT = $clog2(STBW);

  logic [ADRW-1:0] q_addr [QDEPTH];
  logic [7:0]      q_len  [QDEPTH];
  logic [SEQW-1:0] q_seq  [QDEPTH];
  logic [QAW:0]    wr_ptr, rd_ptr;
  logic [SEQW-1:0] seq_cnt;
  logic            fifo_empty, fifo_full, enq, head_avail;
  logic [ADRW-1:0] head_addr;
  logic [7:0]      head_len;
  logic [SEQW-1:0] head_seq;

  logic [NID-1:0]  busy, busy_set, busy_clr;
  logic [SEQW-1:0] seq_tab [NID];
  logic            free_found;
  logic [TAGW-1:0] free_id;
  logic [INW-1:0]  inflight;

  logic            ar_load, cross_4k;
  logic [31:0]     span;
  logic            arvalid_q;
  logic [TAGW-1:0] arid_q;
  logic [ADRW-1:0] araddr_q;
  logic [7:0]      arlen_q;

  logic            rready_int, r_acc, r_hit, r_fwd, r_free;
  logic            cpl_valid_q, cpl_last_q;
  logic [SEQW-1:0] cpl_seq_q;
  logic [DATW-1:0] cpl_data_q;
  logic [1:0]      cpl_resp_q;
  logic            err_q;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[QAW] != rd_ptr[QAW]) && (wr_ptr[QAW-1:0] == rd_ptr[QAW-1:0]);
  // Full is judged on registered state only, so a same-cycle dequeue never frees a slot.
  assign enq        = req_valid & ~fifo_full;
  // An empty FIFO lets an arriving request bypass straight into the AR register.
  assign head_avail = ~fifo_empty | enq;

  always_comb begin
    head_addr = q_addr[rd_ptr[QAW-1:0]];
    head_len  = q_len[rd_ptr[QAW-1:0]];
    head_seq  = q_seq[rd_ptr[QAW-1:0]];
    if (fifo_empty) begin
      head_addr = req_addr;
      head_len  = req_len;
      head_seq  = seq_cnt;
    end
  end

  // Lowest-numbered free ID: scan downward so the last hit is the smallest index.
  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = NID-1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_id    = TAGW'(i);
      end
    end
  end

  assign span     = 32'(head_addr[11:0]) + ((32'(head_len) + 32'd1) << SHIFT);
  assign cross_4k = (span > 32'd4096);
  assign ar_load  = (~arvalid_q | m_axi.arready) & head_avail &
                    (inflight < INW'(MAXOUT)) & free_found;

  assign rready_int = ~cpl_valid_q | i_cpl_ready;
  assign r_acc      = m_axi.rvalid & rready_int;
  assign r_hit      = busy[m_axi.rid];
  assign r_fwd      = r_acc & r_hit;
  assign r_free     = r_fwd & m_axi.rlast;
  assign busy_set   = ar_load ? (NID'(1) << free_id) : '0;
  assign busy_clr   = r_free ? (NID'(1) << m_axi.rid) : '0;

  always_ff @(posedge i_clk) begin
    if (enq) begin
      q_addr[wr_ptr[QAW-1:0]] <= req_addr;
      q_len[wr_ptr[QAW-1:0]]  <= req_len;
      q_seq[wr_ptr[QAW-1:0]]  <= seq_cnt;
    end
    if (ar_load) begin
      seq_tab[free_id] <= head_seq;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      seq_cnt     <= '0;
      busy        <= '0;
      inflight    <= '0;
      arvalid_q   <= 1'b0;
      arid_q      <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      cpl_valid_q <= 1'b0;
      cpl_seq_q   <= '0;
      cpl_data_q  <= '0;
      cpl_resp_q  <= '0;
      cpl_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr  <= wr_ptr + 1'b1;
        seq_cnt <= seq_cnt + 1'b1;
      end
      if (ar_load) begin
        rd_ptr    <= rd_ptr + 1'b1;
        arvalid_q <= 1'b1;
        arid_q    <= free_id;
        araddr_q  <= head_addr;
        arlen_q   <= head_len;
      end else if (m_axi.arready) begin
        arvalid_q <= 1'b0;
      end
      // A freed ID is only seen as free from the next cycle because busy is registered.
      busy     <= (busy | busy_set) & ~busy_clr;
      inflight <= inflight + INW'(ar_load) - INW'(r_free);
      if (r_fwd) begin
        cpl_seq_q  <= seq_tab[m_axi.rid];
        cpl_data_q <= m_axi.rdata;
        cpl_resp_q <= m_axi.rresp;
        cpl_last_q <= m_axi.rlast;
      end
      cpl_valid_q <= r_fwd | (cpl_valid_q & ~i_cpl_ready);
      if ((r_fwd && m_axi.rresp != 2'b00) || (r_acc && !r_hit) || (ar_load && cross_4k)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Outputs are forced low for the whole reset assertion, not just after the reset edge.
  assign req_ready      = ~i_rst & ~fifo_full;
  assign m_axi.arid     = i_rst ? '0 : arid_q;
  assign m_axi.araddr   = i_rst ? '0 : araddr_q;
  assign m_axi.arlen    = i_rst ? '0 : arlen_q;
  assign m_axi.arsize   = SIZE;
  assign m_axi.arburst  = 2'b01;
  assign m_axi.arvalid  = ~i_rst & arvalid_q;
  assign m_axi.rready   = ~i_rst & rready_int;
  assign o_cpl_seq      = i_rst ? '0 : cpl_seq_q;
  assign o_cpl_data     = i_rst ? '0 : cpl_data_q;
  assign o_cpl_resp     = i_rst ? '0 : cpl_resp_q;
  assign o_cpl_last     = ~i_rst & cpl_last_q;
  assign o_cpl_valid    = ~i_rst & cpl_valid_q;
  assign o_inflight     = i_rst ? '0 : inflight;
  assign o_err          = ~i_rst & err_q;
endmodule

// File: tb/tb_axi4_m_rd_mo.sv
// Directed testbench for axi4_m_rd_mo: reset, single burst, back-to-back issue with
// ID recycling, out-of-order R, completion backpressure, error flags, 4KB crossing
// and a reset with bursts in flight.
module tb_axi4_m_rd_mo;
  logic          i_clk;
  logic          i_rst;
  logic [63:0]   req_addr;
  logic [7:0]    req_len;
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    o_cpl_seq;
  logic [255:0]  o_cpl_data;
  logic [1:0]    o_cpl_resp;
  logic          o_cpl_last;
  logic          o_cpl_valid;
  logic          i_cpl_ready;
  logic [2:0]    o_inflight;
  logic          o_err;
  int            n_cmp;
  int            n_bad;

  axi4_m_rd_mo_if #(.TAGW(3), .ADRW(64), .DATW(256)) bus ();

  axi4_m_rd_mo #(
    .TAGW(3), .ADRW(64), .DATW(256), .SIZE(3'b101), .QDEPTH(4), .MAXOUT(4), .SEQW(8)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .req_addr(req_addr), .req_len(req_len), .req_valid(req_valid), .req_ready(req_ready),
    .m_axi(bus.master),
    .o_cpl_seq(o_cpl_seq), .o_cpl_data(o_cpl_data), .o_cpl_resp(o_cpl_resp),
    .o_cpl_last(o_cpl_last), .o_cpl_valid(o_cpl_valid), .i_cpl_ready(i_cpl_ready),
    .o_inflight(o_inflight), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [255:0] pat(input int k);
    return {8{32'hA500_0000 + 32'(k)}};
  endfunction

  task automatic drive_r(input logic v, input logic [2:0] id, input logic [255:0] d,
                         input logic [1:0] resp, input logic last);
    bus.rvalid = v;
    bus.rid    = id;
    bus.rdata  = d;
    bus.rresp  = resp;
    bus.rlast  = last;
  endtask

  task automatic do_reset();
    i_rst     = 1'b1;
    req_valid = 1'b0;
    drive_r(1'b0, 3'd0, '0, 2'b00, 1'b0);
    step();
    step();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    n_cmp++; if ({req_ready, bus.arvalid, bus.rready, o_cpl_valid, o_err} !== 5'b0) begin
      n_bad++; $display("[TB] FAIL reset_outputs got %b exp 00000", {req_ready, bus.arvalid, bus.rready, o_cpl_valid, o_err}); end
    n_cmp++; if ({bus.arsize, bus.arburst} !== {3'b101, 2'b01}) begin
      n_bad++; $display("[TB] FAIL reset_arsize_burst got %b exp 10101", {bus.arsize, bus.arburst}); end
    n_cmp++; if (o_inflight !== 3'd0) begin
      n_bad++; $display("[TB] FAIL reset_inflight got %0d exp 0", o_inflight); end
    i_rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin
      n_bad++; $display("[TB] FAIL release_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_single();
    bus.arready = 1'b1;
    req_addr = 64'h1000; req_len = 8'd3; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    n_cmp++; if ({bus.arvalid, bus.arid, bus.arlen} !== {1'b1, 3'd0, 8'd3}) begin
      n_bad++; $display("[TB] FAIL single_ar got %h exp %h", {bus.arvalid, bus.arid, bus.arlen}, {1'b1, 3'd0, 8'd3}); end
    n_cmp++; if (bus.araddr !== 64'h1000) begin
      n_bad++; $display("[TB] FAIL single_araddr got %h exp 1000", bus.araddr); end
    n_cmp++; if (o_inflight !== 3'd1) begin
      n_bad++; $display("[TB] FAIL single_inflight1 got %0d exp 1", o_inflight); end
    step();
    n_cmp++; if (bus.arvalid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL single_ar_drop got %b exp 0", bus.arvalid); end
    for (int b = 0; b < 4; b++) begin
      drive_r(1'b1, 3'd0, pat(b), 2'b00, (b == 3));
      step();
      n_cmp++; if ({o_cpl_valid, o_cpl_seq, o_cpl_resp, o_cpl_last} !== {1'b1, 8'd0, 2'b00, (b == 3)}) begin
        n_bad++; $display("[TB] FAIL single_cpl%0d got %h exp %h", b, {o_cpl_valid, o_cpl_seq, o_cpl_resp, o_cpl_last}, {1'b1, 8'd0, 2'b00, (b == 3)}); end
      n_cmp++; if (o_cpl_data !== pat(b)) begin
        n_bad++; $display("[TB] FAIL single_data%0d got %h exp %h", b, o_cpl_data, pat(b)); end
    end
    drive_r(1'b0, 3'd0, '0, 2'b00, 1'b0);
    n_cmp++; if (o_inflight !== 3'd0) begin
      n_bad++; $display("[TB] FAIL single_inflight0 got %0d exp 0", o_inflight); end
    step();
    n_cmp++; if (o_cpl_valid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL single_cpl_idle got %b exp 0", o_cpl_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.arready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_addr = 64'h2000 + 64'(i) * 64'h100; req_len = 8'd0; req_valid = 1'b1;
      step();
      if (i < 4) begin
        n_cmp++; if ({bus.arvalid, bus.arid, bus.araddr} !== {1'b1, 3'(i), 64'h2000 + 64'(i) * 64'h100}) begin
          n_bad++; $display("[TB] FAIL b2b_ar%0d got %h exp %h", i, {bus.arvalid, bus.arid, bus.araddr}, {1'b1, 3'(i), 64'h2000 + 64'(i) * 64'h100}); end
      end else if (i == 4) begin
        n_cmp++; if (bus.arvalid !== 1'b0) begin
          n_bad++; $display("[TB] FAIL b2b_maxout_stall got %b exp 0", bus.arvalid); end
      end
    end
    req_valid = 1'b0;
    n_cmp++; if ({o_inflight, req_ready} !== {3'd4, 1'b1}) begin
      n_bad++; $display("[TB] FAIL b2b_inflight got %b exp 1001", {o_inflight, req_ready}); end
    drive_r(1'b1, 3'd2, pat(20), 2'b00, 1'b1);
    step();
    drive_r(1'b0, 3'd0, '0, 2'b00, 1'b0);
    n_cmp++; if ({o_cpl_valid, o_cpl_seq, o_cpl_last, o_inflight, bus.arvalid} !== {1'b1, 8'd2, 1'b1, 3'd3, 1'b0}) begin
      n_bad++; $display("[TB] FAIL b2b_free_id2 got %h exp %h", {o_cpl_valid, o_cpl_seq, o_cpl_last, o_inflight, bus.arvalid}, {1'b1, 8'd2, 1'b1, 3'd3, 1'b0}); end
    step();
    n_cmp++; if ({bus.arvalid, bus.arid, bus.araddr, o_inflight} !== {1'b1, 3'd2, 64'h2400, 3'd4}) begin
      n_bad++; $display("[TB] FAIL b2b_reissue_id2 got %h exp %h", {bus.arvalid, bus.arid, bus.araddr, o_inflight}, {1'b1, 3'd2, 64'h2400, 3'd4}); end
    step();
  endtask

  // Busy on entry: id0 seq0, id1 seq1, id2 seq4, id3 seq3; seq5 (0x2500) queued.
  task automatic test_out_of_order();
    int oo_id [4]   = '{1, 1, 0, 0};
    int oo_last [4] = '{0, 1, 0, 1};
    int oo_seq [4]  = '{1, 1, 0, 0};
    for (int k = 0; k < 4; k++) begin
      drive_r(1'b1, 3'(oo_id[k]), pat(30 + k), 2'b00, oo_last[k] != 0);
      step();
      n_cmp++; if ({o_cpl_valid, o_cpl_seq, o_cpl_last} !== {1'b1, 8'(oo_seq[k]), oo_last[k] != 0}) begin
        n_bad++; $display("[TB] FAIL ooo_cpl%0d got %h exp %h", k, {o_cpl_valid, o_cpl_seq, o_cpl_last}, {1'b1, 8'(oo_seq[k]), oo_last[k] != 0}); end
      n_cmp++; if (o_cpl_data !== pat(30 + k)) begin
        n_bad++; $display("[TB] FAIL ooo_data%0d got %h exp %h", k, o_cpl_data, pat(30 + k)); end
      if (k == 2) begin
        n_cmp++; if ({bus.arvalid, bus.arid, bus.araddr} !== {1'b1, 3'd1, 64'h2500}) begin
          n_bad++; $display("[TB] FAIL ooo_reissue_id1 got %h exp %h", {bus.arvalid, bus.arid, bus.araddr}, {1'b1, 3'd1, 64'h2500}); end
      end
    end
    drive_r(1'b0, 3'd0, '0, 2'b00, 1'b0);
    n_cmp++; if (o_inflight !== 3'd3) begin
      n_bad++; $display("[TB] FAIL ooo_inflight got %0d exp 3", o_inflight); end
    step();
  endtask

  // Busy on entry: id1 seq5, id2 seq4, id3 seq3.
  task automatic test_backpressure();
    i_cpl_ready = 1'b1;
    drive_r(1'b1, 3'd3, pat(40), 2'b00, 1'b0);
    step();
    n_cmp++; if ({o_cpl_valid, o_cpl_data} !== {1'b1, pat(40)}) begin
      n_bad++; $display("[TB] FAIL bp_first got %h exp %h", {o_cpl_valid, o_cpl_data}, {1'b1, pat(40)}); end
    i_cpl_ready = 1'b0;
    drive_r(1'b1, 3'd3, pat(41), 2'b00, 1'b0);
    #1;
    n_cmp++; if (bus.rready !== 1'b0) begin
      n_bad++; $display("[TB] FAIL bp_rready_low got %b exp 0", bus.rready); end
    for (int s = 0; s < 5; s++) begin
      step();
      n_cmp++; if ({o_cpl_valid, bus.rready, o_cpl_data} !== {1'b1, 1'b0, pat(40)}) begin
        n_bad++; $display("[TB] FAIL bp_hold%0d got %h exp %h", s, {o_cpl_valid, bus.rready, o_cpl_data}, {1'b1, 1'b0, pat(40)}); end
    end
    i_cpl_ready = 1'b1;
    #1;
    n_cmp++; if (bus.rready !== 1'b1) begin
      n_bad++; $display("[TB] FAIL bp_rready_high got %b exp 1", bus.rready); end
    for (int b = 1; b < 4; b++) begin
      if (b > 1) drive_r(1'b1, 3'd3, pat(40 + b), 2'b00, (b == 3));
      step();
      n_cmp++; if ({o_cpl_valid, o_cpl_seq, o_cpl_last, o_cpl_data} !== {1'b1, 8'd3, (b == 3), pat(40 + b)}) begin
        n_bad++; $display("[TB] FAIL bp_beat%0d got %h exp %h", b, {o_cpl_valid, o_cpl_seq, o_cpl_last, o_cpl_data}, {1'b1, 8'd3, (b == 3), pat(40 + b)}); end
    end
    drive_r(1'b0, 3'd0, '0, 2'b00, 1'b0);
    n_cmp++; if (o_inflight !== 3'd2) begin
      n_bad++; $display("[TB] FAIL bp_inflight got %0d exp 2", o_inflight); end
    step();
    n_cmp++; if (o_cpl_valid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL bp_idle got %b exp 0", o_cpl_valid); end
  endtask

  // Busy on entry: id1 seq5, id2 seq4.
  task automatic test_errors();
    n_cmp++; if (o_err !== 1'b0) begin
      n_bad++; $display("[TB] FAIL err_clean got %b exp 0", o_err); end
    drive_r(1'b1, 3'd2, pat(50), 2'b10, 1'b1);
    step();
    drive_r(1'b0, 3'd0, '0, 2'b00, 1'b0);
    n_cmp++; if ({o_cpl_valid, o_cpl_resp, o_cpl_seq, o_err} !== {1'b1, 2'b10, 8'd4, 1'b1}) begin
      n_bad++; $display("[TB] FAIL err_rresp got %h exp %h", {o_cpl_valid, o_cpl_resp, o_cpl_seq, o_err}, {1'b1, 2'b10, 8'd4, 1'b1}); end
    step();
    step();
    n_cmp++; if ({o_err, o_inflight} !== {1'b1, 3'd1}) begin
      n_bad++; $display("[TB] FAIL err_sticky got %b exp 1001", {o_err, o_inflight}); end
    do_reset();
    #1;
    n_cmp++; if (o_err !== 1'b0) begin
      n_bad++; $display("[TB] FAIL err_reset_clear got %b exp 0", o_err); end
    drive_r(1'b1, 3'd5, pat(51), 2'b00, 1'b1);
    step();
    drive_r(1'b0, 3'd0, '0, 2'b00, 1'b0);
    n_cmp++; if ({o_cpl_valid, o_err, o_inflight} !== {1'b0, 1'b1, 3'd0}) begin
      n_bad++; $display("[TB] FAIL err_idle_rid got %b exp 01000", {o_cpl_valid, o_err, o_inflight}); end
    step();
  endtask

  task automatic test_4k_cross();
    do_reset();
    bus.arready = 1'b1;
    req_addr = 64'h0FE0; req_len = 8'd0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    n_cmp++; if ({bus.arvalid, bus.araddr, o_err} !== {1'b1, 64'h0FE0, 1'b0}) begin
      n_bad++; $display("[TB] FAIL x4k_exact_edge got %h exp %h", {bus.arvalid, bus.araddr, o_err}, {1'b1, 64'h0FE0, 1'b0}); end
    req_addr = 64'h1FE0; req_len = 8'd1; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    n_cmp++; if ({bus.arvalid, bus.arid, bus.araddr, bus.arlen, o_err} !== {1'b1, 3'd1, 64'h1FE0, 8'd1, 1'b1}) begin
      n_bad++; $display("[TB] FAIL x4k_cross got %h exp %h", {bus.arvalid, bus.arid, bus.araddr, bus.arlen, o_err}, {1'b1, 3'd1, 64'h1FE0, 8'd1, 1'b1}); end
    step();
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.arready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 64'h3000 + 64'(i) * 64'h40; req_len = 8'd0; req_valid = 1'b1;
      step();
    end
    req_valid = 1'b0;
    n_cmp++; if ({o_inflight, bus.arvalid, bus.arid} !== {3'd3, 1'b1, 3'd2}) begin
      n_bad++; $display("[TB] FAIL mr_pre got %b exp 0111010", {o_inflight, bus.arvalid, bus.arid}); end
    i_rst = 1'b1;
    #1;
    n_cmp++; if ({bus.arvalid, o_inflight, req_ready} !== {1'b0, 3'd0, 1'b0}) begin
      n_bad++; $display("[TB] FAIL mr_during got %b exp 00000", {bus.arvalid, o_inflight, req_ready}); end
    step();
    i_rst = 1'b0;
    #1;
    n_cmp++; if ({req_ready, o_inflight, bus.arvalid} !== {1'b1, 3'd0, 1'b0}) begin
      n_bad++; $display("[TB] FAIL mr_release got %b exp 10000", {req_ready, o_inflight, bus.arvalid}); end
    req_addr = 64'h4000; req_len = 8'd0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    n_cmp++; if ({bus.arvalid, bus.arid, bus.araddr} !== {1'b1, 3'd0, 64'h4000}) begin
      n_bad++; $display("[TB] FAIL mr_new_ar got %h exp %h", {bus.arvalid, bus.arid, bus.araddr}, {1'b1, 3'd0, 64'h4000}); end
    drive_r(1'b1, 3'd1, pat(60), 2'b00, 1'b1);
    step();
    n_cmp++; if ({o_cpl_valid, o_err} !== 2'b01) begin
      n_bad++; $display("[TB] FAIL mr_late_r got %b exp 01", {o_cpl_valid, o_err}); end
    drive_r(1'b1, 3'd0, pat(61), 2'b00, 1'b1);
    step();
    drive_r(1'b0, 3'd0, '0, 2'b00, 1'b0);
    n_cmp++; if ({o_cpl_valid, o_cpl_seq, o_cpl_data, o_inflight} !== {1'b1, 8'd0, pat(61), 3'd0}) begin
      n_bad++; $display("[TB] FAIL mr_new_cpl got %h exp %h", {o_cpl_valid, o_cpl_seq, o_cpl_data, o_inflight}, {1'b1, 8'd0, pat(61), 3'd0}); end
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    i_rst = 1'b1;
    req_addr = '0;
    req_len = '0;
    req_valid = 1'b0;
    i_cpl_ready = 1'b1;
    bus.arready = 1'b0;
    drive_r(1'b0, 3'd0, '0, 2'b00, 1'b0);
    test_reset();
    test_single();
    test_back_to_back();
    test_out_of_order();
    test_backpressure();
    test_errors();
    test_4k_cross();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
